phase_sequencer: RTL and testbench

//   Intersection phase FSM for smartFlow. Drives the countdown timer through start/load_val
//   and consumes its done flag, stepping NS/EW signal heads through green, yellow and all-red.

---
 rtl/phase_sequencer.sv | 177 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: intersection phase FSM that arms a downstream countdown timer and steps NS/EW heads.
// Latency: lights, phase and tmr_start are registered and change on the edge entering a phase's ARM cycle.
// Flow: one-cycle tmr_start strobe per phase, advance on tmr_done; optional WALK phase under SMARTFLOW_PED_EN.
module phase_sequencer #(
  parameter int WIDTH    = 8,
  parameter int T_GREEN  = 20,
  parameter int T_EXT    = 8,
  parameter int MAX_EXT  = 3,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ns_car,
  input  logic             ew_car,
  input  logic             tmr_done,
  output logic             tmr_start,
  output logic [WIDTH-1:0] tmr_load,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic [2:0]       phase
`ifdef SMARTFLOW_PED_EN
  ,
  input  logic             ped_req,
  output logic             walk
`endif
);

  localparam int               EXT_W     = $clog2(MAX_EXT + 2);
  localparam logic [EXT_W-1:0] EXT_MAX   = EXT_W'(MAX_EXT);
  localparam logic [WIDTH-1:0] LD_GREEN  = WIDTH'(T_GREEN);
  localparam logic [WIDTH-1:0] LD_EXT    = WIDTH'(T_EXT);
  localparam logic [WIDTH-1:0] LD_YELLOW = WIDTH'(T_YELLOW);
  localparam logic [WIDTH-1:0] LD_ALLRED = WIDTH'(T_ALLRED);
  localparam logic [WIDTH-1:0] LD_WALK   = WIDTH'(T_WALK);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_AR   = 3'd1;
  localparam logic [2:0] PH_NSG  = 3'd2;
  localparam logic [2:0] PH_NSY  = 3'd3;
  localparam logic [2:0] PH_EWG  = 3'd4;
  localparam logic [2:0] PH_EWY  = 3'd5;
  localparam logic [2:0] PH_WALK = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_AR_ARM, S_AR_WAIT, S_NSG_ARM, S_NSG_WAIT, S_NSY_ARM, S_NSY_WAIT,
    S_EWG_ARM, S_EWG_WAIT, S_EWY_ARM, S_EWY_WAIT, S_WALK_ARM, S_WALK_WAIT
  } state_t;

  typedef enum logic {DIR_NS, DIR_EW} dir_t;

  state_t             state, state_nxt;
  dir_t               dir, dir_nxt;
  logic [EXT_W-1:0]   ext_cnt, ext_nxt;
  logic               start_nxt;
  logic [WIDTH-1:0]   load_nxt;
  logic [1:0]         ns_nxt, ew_nxt;
  logic [2:0]         phase_nxt;
  logic               ped_pend;
  state_t             green_sel;

  // ns_car is reserved for future priority logic; the FSM deliberately ignores it.
  logic unused_ns_car;
  assign unused_ns_car = ns_car;

  assign green_sel = (dir == DIR_NS) ? S_NSG_ARM : S_EWG_ARM;

  // Next state, timer arming and extension bookkeeping; tmr_done is ignored in ARM states (stale).
  // EW green never extends: its opposing sensor is not used for decisions.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    ext_nxt   = ext_cnt;
    start_nxt = 1'b0;
    load_nxt  = tmr_load;
    case (state)
      S_IDLE:      begin state_nxt = S_AR_ARM; start_nxt = 1'b1; load_nxt = LD_ALLRED; end
      S_AR_ARM:    state_nxt = S_AR_WAIT;
      S_AR_WAIT:   if (tmr_done) begin
                     start_nxt = 1'b1;
                     if (ped_pend) begin state_nxt = S_WALK_ARM; load_nxt = LD_WALK; end
                     else          begin state_nxt = green_sel;  load_nxt = LD_GREEN; end
                   end
      S_WALK_ARM:  state_nxt = S_WALK_WAIT;
      S_WALK_WAIT: if (tmr_done) begin state_nxt = green_sel; start_nxt = 1'b1; load_nxt = LD_GREEN; end
      S_NSG_ARM:   state_nxt = S_NSG_WAIT;
      S_NSG_WAIT:  if (tmr_done) begin
                     start_nxt = 1'b1;
                     if (!ew_car && (ext_cnt < EXT_MAX) && !ped_pend) begin
                       state_nxt = S_NSG_ARM;
                       load_nxt  = LD_EXT;
                       ext_nxt   = ext_cnt + EXT_W'(1);
                     end else begin
                       state_nxt = S_NSY_ARM;
                       load_nxt  = LD_YELLOW;
                       ext_nxt   = '0;
                     end
                   end
      S_NSY_ARM:   state_nxt = S_NSY_WAIT;
      S_NSY_WAIT:  if (tmr_done) begin
                     state_nxt = S_AR_ARM; start_nxt = 1'b1; load_nxt = LD_ALLRED; dir_nxt = DIR_EW;
                   end
      S_EWG_ARM:   state_nxt = S_EWG_WAIT;
      S_EWG_WAIT:  if (tmr_done) begin
                     state_nxt = S_EWY_ARM; start_nxt = 1'b1; load_nxt = LD_YELLOW; ext_nxt = '0;
                   end
      S_EWY_ARM:   state_nxt = S_EWY_WAIT;
      S_EWY_WAIT:  if (tmr_done) begin
                     state_nxt = S_AR_ARM; start_nxt = 1'b1; load_nxt = LD_ALLRED; dir_nxt = DIR_NS;
                   end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Lights and phase code for the state being entered; an extension re-arm keeps the same values.
  always_comb begin
    ns_nxt    = RED;
    ew_nxt    = RED;
    phase_nxt = PH_IDLE;
    case (state_nxt)
      S_AR_ARM, S_AR_WAIT:     phase_nxt = PH_AR;
      S_NSG_ARM, S_NSG_WAIT:   begin phase_nxt = PH_NSG; ns_nxt = GRN; end
      S_NSY_ARM, S_NSY_WAIT:   begin phase_nxt = PH_NSY; ns_nxt = YEL; end
      S_EWG_ARM, S_EWG_WAIT:   begin phase_nxt = PH_EWG; ew_nxt = GRN; end
      S_EWY_ARM, S_EWY_WAIT:   begin phase_nxt = PH_EWY; ew_nxt = YEL; end
      S_WALK_ARM, S_WALK_WAIT: phase_nxt = PH_WALK;
      default:                 phase_nxt = PH_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      dir       <= DIR_NS;
      ext_cnt   <= '0;
      tmr_start <= 1'b0;
      tmr_load  <= '0;
      ns_light  <= RED;
      ew_light  <= RED;
      phase     <= PH_IDLE;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      ext_cnt   <= ext_nxt;
      tmr_start <= start_nxt;
      tmr_load  <= load_nxt;
      ns_light  <= ns_nxt;
      ew_light  <= ew_nxt;
      phase     <= phase_nxt;
    end
  end

`ifdef SMARTFLOW_PED_EN
  // Pedestrian latch: cleared on the WALK-entry edge (beats a same-cycle request), ignored during WALK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend <= 1'b0;
      walk     <= 1'b0;
    end else begin
      if (state_nxt == S_WALK_ARM)
        ped_pend <= 1'b0;
      else if (ped_req && (state != S_WALK_ARM) && (state != S_WALK_WAIT))
        ped_pend <= 1'b1;
      walk <= (state_nxt == S_WALK_ARM) || (state_nxt == S_WALK_WAIT);
    end
  end
`else
  assign ped_pend = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed bench for phase_sequencer with a behavioural countdown timer attached.
// Timer: start edge loads count and clears done; done rises T+1 edges after the start edge.
// Parameters: WIDTH=8 T_GREEN=5 T_EXT=3 MAX_EXT=2 T_YELLOW=2 T_ALLRED=1 T_WALK=4.
module tb_phase_sequencer;

  logic       clk;
  logic       reset_n;
  logic       ns_car;
  logic       ew_car;
  logic       tmr_done;
  logic       tmr_start;
  logic [7:0] tmr_load;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic [2:0] phase;
  logic [7:0] t_cnt;
`ifdef SMARTFLOW_PED_EN
  logic       ped_req;
  logic       walk;
  logic       ped_sch [64];
  logic       pend_tr [64];
  logic       wk_tr   [64];
`endif

  logic       ew_sch [64];
  logic       st_tr  [64];
  logic [7:0] ld_tr  [64];
  logic [2:0] ph_tr  [64];
  logic [1:0] ns_tr  [64];
  logic [1:0] ew_tr  [64];
  int         ext_tr [64];

  int checks = 0;
  int errors = 0;

  phase_sequencer #(
    .WIDTH(8), .T_GREEN(5), .T_EXT(3), .MAX_EXT(2), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ns_car    (ns_car),
    .ew_car    (ew_car),
    .tmr_done  (tmr_done),
    .tmr_start (tmr_start),
    .tmr_load  (tmr_load),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .phase     (phase)
`ifdef SMARTFLOW_PED_EN
    ,
    .ped_req   (ped_req),
    .walk      (walk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Countdown timer model
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_cnt    <= 8'd0;
      tmr_done <= 1'b0;
    end else if (tmr_start) begin
      t_cnt    <= tmr_load;
      tmr_done <= 1'b0;
    end else if (t_cnt != 8'd0) begin
      t_cnt    <= t_cnt - 8'd1;
      tmr_done <= (t_cnt == 8'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arm(input string tag, input int c, input int ld, input int ph);
    chk({tag, "_start"}, 32'(st_tr[c]), 32'd1);
    chk({tag, "_load"},  32'(ld_tr[c]), 32'(ld));
    chk({tag, "_phase"}, 32'(ph_tr[c]), 32'(ph));
  endtask

  function automatic int count_starts(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) if (st_tr[i] === 1'b1) k++;
    return k;
  endfunction

  // Release reset at a falling edge (cycle 0 = IDLE) and record n cycles of outputs
  task automatic run_trace(input int n);
    reset_n = 1'b1;
    for (int c = 0; c < n; c++) begin
      ew_car = ew_sch[c];
`ifdef SMARTFLOW_PED_EN
      ped_req = ped_sch[c];
`endif
      #1;
      st_tr[c]  = tmr_start;
      ld_tr[c]  = tmr_load;
      ph_tr[c]  = phase;
      ns_tr[c]  = ns_light;
      ew_tr[c]  = ew_light;
      ext_tr[c] = int'(dut.ext_cnt);
`ifdef SMARTFLOW_PED_EN
      pend_tr[c] = dut.ped_pend;
      wk_tr[c]   = walk;
`endif
      @(negedge clk);
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    ew_car  = 1'b0;
`ifdef SMARTFLOW_PED_EN
    ped_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    ns_car  = 1'b0;
    ew_car  = 1'b1;
`ifdef SMARTFLOW_PED_EN
    ped_req = 1'b0;
    for (int i = 0; i < 64; i++) ped_sch[i] = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_start", 32'(tmr_start), 32'd0);
    chk("rst_load",  32'(tmr_load),  32'd0);
    chk("rst_ns",    32'(ns_light),  32'd0);
    chk("rst_ew",    32'(ew_light),  32'd0);
    chk("rst_phase", 32'(phase),     32'd0);

    // Test 1: EW demand present, no extension
    for (int i = 0; i < 64; i++) ew_sch[i] = 1'b1;
    run_trace(20);
    chk("t1_idle_phase", 32'(ph_tr[0]), 32'd0);
    chk("t1_idle_start", 32'(st_tr[0]), 32'd0);
    chk("t1_nstarts", 32'(count_starts(20)), 32'd5);
    chk_arm("t1_ar0", 1, 1, 1);
    chk_arm("t1_nsg", 4, 5, 2);
    chk_arm("t1_nsy", 11, 2, 3);
    chk_arm("t1_ar1", 15, 1, 1);
    chk_arm("t1_ewg", 18, 5, 4);
    chk("t1_ar_ns",  32'(ns_tr[1]),  32'd0);
    chk("t1_nsg_ns", 32'(ns_tr[4]),  32'd2);
    chk("t1_nsg_ew", 32'(ew_tr[4]),  32'd0);
    chk("t1_nsy_ns", 32'(ns_tr[11]), 32'd1);
    chk("t1_ewg_ew", 32'(ew_tr[18]), 32'd2);
    chk("t1_ewg_ns", 32'(ns_tr[18]), 32'd0);

    // Test 2: no EW demand -> two extensions; ns_car toggled high to show it is ignored
    hold_reset();
    ns_car = 1'b1;
    for (int i = 0; i < 64; i++) ew_sch[i] = 1'b0;
    run_trace(29);
    chk("t2_nstarts", 32'(count_starts(29)), 32'd7);
    chk_arm("t2_nsg",  4, 5, 2);
    chk_arm("t2_ext1", 11, 3, 2);
    chk_arm("t2_ext2", 16, 3, 2);
    chk_arm("t2_nsy",  21, 2, 3);
    chk_arm("t2_ar",   25, 1, 1);
    chk_arm("t2_ewg",  28, 5, 4);
    chk("t2_ext_ns_held", 32'(ns_tr[11]), 32'd2);
    chk("t2_ext_cnt_max", 32'(ext_tr[20]), 32'd2);
    chk("t2_ext_cnt_ewg", 32'(ext_tr[28]), 32'd0);
    ns_car = 1'b0;

    // Test 3: EW demand appears right after the first green done -> one extension
    hold_reset();
    for (int i = 0; i < 64; i++) ew_sch[i] = (i >= 11);
    run_trace(24);
    chk("t3_nstarts", 32'(count_starts(24)), 32'd6);
    chk_arm("t3_ext1", 11, 3, 2);
    chk_arm("t3_nsy",  16, 2, 3);
    chk_arm("t3_ar",   20, 1, 1);
    chk_arm("t3_ewg",  23, 5, 4);

    // Test 4: asynchronous reset three cycles into NS green WAIT
    hold_reset();
    ew_car  = 1'b1;
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("t4_pre_phase", 32'(phase), 32'd2);
    chk("t4_pre_ns",    32'(ns_light), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_ns",    32'(ns_light),  32'd0);
    chk("t4_rst_ew",    32'(ew_light),  32'd0);
    chk("t4_rst_start", 32'(tmr_start), 32'd0);
    chk("t4_rst_phase", 32'(phase),     32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t4_idle_phase", 32'(phase),     32'd0);
    chk("t4_idle_start", 32'(tmr_start), 32'd0);
    @(negedge clk);
    chk("t4_ar_start", 32'(tmr_start), 32'd1);
    chk("t4_ar_load",  32'(tmr_load),  32'd1);
    chk("t4_ar_phase", 32'(phase),     32'd1);

`ifdef SMARTFLOW_PED_EN
    // Test 5: pedestrian request in NS green blocks extension, WALK follows all-red
    hold_reset();
    for (int i = 0; i < 64; i++) begin ew_sch[i] = 1'b0; ped_sch[i] = (i == 6); end
    run_trace(26);
    chk("t5_nstarts", 32'(count_starts(26)), 32'd6);
    chk("t5_pend_set", 32'(pend_tr[10]), 32'd1);
    chk_arm("t5_nsy",  11, 2, 3);
    chk_arm("t5_ar",   15, 1, 1);
    chk_arm("t5_walk", 18, 4, 6);
    chk("t5_pend_clr",  32'(pend_tr[18]), 32'd0);
    chk("t5_walk_on",   32'(wk_tr[18]),   32'd1);
    chk("t5_walk_last", 32'(wk_tr[23]),   32'd1);
    chk("t5_walk_ns",   32'(ns_tr[20]),   32'd0);
    chk("t5_walk_ew",   32'(ew_tr[20]),   32'd0);
    chk_arm("t5_ewg",  24, 5, 4);
    chk("t5_walk_off",  32'(wk_tr[24]),   32'd0);

    // Test 6: request held through WALK does not repeat it; a later request does
    hold_reset();
    ns_car = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ew_sch[i]  = 1'b1;
      ped_sch[i] = ((i >= 2) && (i <= 9)) || (i == 26);
    end
    run_trace(40);
    chk_arm("t6_walk1", 4, 4, 6);
    chk("t6_pend_clr_win", 32'(pend_tr[4]), 32'd0);
    chk("t6_pend_in_walk", 32'(pend_tr[9]), 32'd0);
    chk_arm("t6_nsg",   10, 5, 2);
    chk_arm("t6_ewg",   24, 5, 4);
    chk("t6_pend_again", 32'(pend_tr[27]), 32'd1);
    chk_arm("t6_walk2", 38, 4, 6);
    ns_car = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
